// File: rtl/tpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tpu_seq_ctrl
// Brief   : Runtime-configurable TPU sequencer: SRAM read feed, systolic
//           window control and backpressured result-row write-out.
// Revision: 1.0 - initial release
// ============================================================================
module tpu_seq_ctrl #(
    parameter int ARRAY_SIZE = 8,
    parameter int ADDR_W     = 10,
    parameter int WADDR_W    = 6,
    parameter int MAX_K      = 64,
    parameter int MAX_SETS   = 16,
    localparam int CW = $clog2(MAX_K + 2*ARRAY_SIZE),
    localparam int KW = $clog2(MAX_K + 1),
    localparam int SW = $clog2(MAX_SETS + 1),
    localparam int RW = $clog2(ARRAY_SIZE)
) (
    input  logic               clk,
    input  logic               srstn,
    input  logic               tpu_start,
    input  logic               abort,
    input  logic [KW-1:0]      cfg_k,
    input  logic [SW-1:0]      cfg_sets,
    input  logic               wr_ready,
    output logic               sram_ren,
    output logic [ADDR_W-1:0]  sram_raddr,
    output logic               alu_start,
    output logic               acc_clear,
    output logic [CW-1:0]      cycle_num,
    output logic [RW-1:0]      out_row_sel,
    output logic               sram_write_enable_a0,
    output logic [WADDR_W-1:0] sram_waddr_a,
    output logic               tpu_busy,
    output logic               tpu_done,
    output logic               err_cfg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // State registers describe the cycle currently visible on the outputs.
    state_t             r_state,   w_state;
    logic [KW-1:0]      r_k,       w_k;
    logic [SW-1:0]      r_sets,    w_sets;
    logic [SW-1:0]      r_set_idx, w_set_idx;
    logic [CW-1:0]      r_cycle,   w_cycle;
    logic [RW-1:0]      r_row,     w_row;
    logic               r_ren,     w_ren;
    logic [ADDR_W-1:0]  r_raddr,   w_raddr;
    logic               r_alu,     w_alu;
    logic               r_acc,     w_acc;
    logic [RW-1:0]      r_row_sel, w_row_sel;
    logic               r_we,      w_we;
    logic [WADDR_W-1:0] r_waddr,   w_waddr;
    logic               r_busy,    w_busy;
    logic               r_done,    w_done;
    logic               r_err,     w_err;

    logic [31:0]        w_cfg_prod;
    logic               w_cfg_ok;
    logic               w_feed_last;
    logic               w_row_last;
    logic               w_set_last;
    logic [CW-1:0]      w_cycle_inc;

    assign w_cfg_prod  = 32'(cfg_k) * 32'(cfg_sets);
    assign w_cfg_ok    = (cfg_k != '0) && (32'(cfg_k) <= 32'(MAX_K)) &&
                         (cfg_sets != '0) && (32'(cfg_sets) <= 32'(MAX_SETS)) &&
                         (w_cfg_prod <= (32'(1) << ADDR_W));
    assign w_feed_last = (32'(r_cycle) == 32'(r_k) + 32'(2*ARRAY_SIZE - 2));
    assign w_row_last  = (32'(r_row) == 32'(ARRAY_SIZE - 1));
    assign w_set_last  = (32'(r_set_idx) + 32'd1 == 32'(r_sets));
    assign w_cycle_inc = r_cycle + 1'b1;

    // Each write-cycle strobe reflects wr_ready sampled at the edge opening
    // that cycle; a strobe that is high marks the row as accepted.
    always_comb begin
        w_state   = r_state;
        w_k       = r_k;
        w_sets    = r_sets;
        w_set_idx = r_set_idx;
        w_cycle   = r_cycle;
        w_row     = r_row;
        w_ren     = 1'b0;
        w_raddr   = r_raddr;
        w_alu     = 1'b0;
        w_acc     = 1'b0;
        w_row_sel = r_row_sel;
        w_we      = 1'b0;
        w_waddr   = r_waddr;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_err     = 1'b0;
        if (abort) begin
            w_state   = S_IDLE;
            w_set_idx = '0;
            w_cycle   = '0;
            w_row     = '0;
            w_raddr   = '0;
            w_row_sel = '0;
            w_waddr   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (tpu_start) begin
                        if (w_cfg_ok) begin
                            w_state   = S_FEED;
                            w_k       = cfg_k;
                            w_sets    = cfg_sets;
                            w_set_idx = '0;
                            w_cycle   = '0;
                            w_ren     = 1'b1;
                            w_raddr   = '0;
                            w_alu     = 1'b1;
                            w_acc     = 1'b1;
                            w_busy    = 1'b1;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                end
                S_FEED: begin
                    w_busy = 1'b1;
                    if (w_feed_last) begin
                        w_state   = S_WRITE;
                        w_row     = '0;
                        w_row_sel = '0;
                        w_we      = wr_ready;
                        w_waddr   = WADDR_W'(32'(r_set_idx) * 32'(ARRAY_SIZE));
                    end else begin
                        w_cycle = w_cycle_inc;
                        w_alu   = 1'b1;
                        if (32'(w_cycle_inc) < 32'(r_k)) begin
                            w_ren   = 1'b1;
                            w_raddr = ADDR_W'(32'(r_set_idx) * 32'(r_k) + 32'(w_cycle_inc));
                        end
                    end
                end
                S_WRITE: begin
                    w_busy = 1'b1;
                    if (!r_we) begin
                        w_we = wr_ready;
                    end else if (!w_row_last) begin
                        w_row     = r_row + 1'b1;
                        w_row_sel = r_row + 1'b1;
                        w_we      = wr_ready;
                        w_waddr   = WADDR_W'(32'(r_set_idx) * 32'(ARRAY_SIZE) + 32'(r_row) + 32'd1);
                    end else if (w_set_last) begin
                        w_state = S_DONE;
                        w_done  = 1'b1;
                    end else begin
                        w_state   = S_FEED;
                        w_set_idx = r_set_idx + 1'b1;
                        w_cycle   = '0;
                        w_ren     = 1'b1;
                        w_raddr   = ADDR_W'((32'(r_set_idx) + 32'd1) * 32'(r_k));
                        w_alu     = 1'b1;
                        w_acc     = 1'b1;
                    end
                end
                S_DONE: begin
                    w_state   = S_IDLE;
                    w_set_idx = '0;
                    w_cycle   = '0;
                    w_row     = '0;
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_sets    <= '0;
            r_set_idx <= '0;
            r_cycle   <= '0;
            r_row     <= '0;
            r_ren     <= 1'b0;
            r_raddr   <= '0;
            r_alu     <= 1'b0;
            r_acc     <= 1'b0;
            r_row_sel <= '0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_k       <= w_k;
            r_sets    <= w_sets;
            r_set_idx <= w_set_idx;
            r_cycle   <= w_cycle;
            r_row     <= w_row;
            r_ren     <= w_ren;
            r_raddr   <= w_raddr;
            r_alu     <= w_alu;
            r_acc     <= w_acc;
            r_row_sel <= w_row_sel;
            r_we      <= w_we;
            r_waddr   <= w_waddr;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_err     <= w_err;
        end
    end

    assign sram_ren             = r_ren;
    assign sram_raddr           = r_raddr;
    assign alu_start            = r_alu;
    assign acc_clear            = r_acc;
    assign cycle_num            = r_cycle;
    assign out_row_sel          = r_row_sel;
    assign sram_write_enable_a0 = r_we;
    assign sram_waddr_a         = r_waddr;
    assign tpu_busy             = r_busy;
    assign tpu_done             = r_done;
    assign err_cfg              = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_tpu_seq_ctrl
// Brief   : Directed self-checking bench for tpu_seq_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tpu_seq_ctrl;

    localparam int ARRAY_SIZE = 8;
    localparam int ADDR_W     = 10;
    localparam int WADDR_W    = 6;
    localparam int MAX_K      = 64;
    localparam int MAX_SETS   = 16;
    localparam int CW = $clog2(MAX_K + 2*ARRAY_SIZE);
    localparam int KW = $clog2(MAX_K + 1);
    localparam int SW = $clog2(MAX_SETS + 1);
    localparam int RW = $clog2(ARRAY_SIZE);

    logic               clk = 1'b0;
    logic               srstn;
    logic               tpu_start;
    logic               abort;
    logic [KW-1:0]      cfg_k;
    logic [SW-1:0]      cfg_sets;
    logic               wr_ready;
    logic               sram_ren;
    logic [ADDR_W-1:0]  sram_raddr;
    logic               alu_start;
    logic               acc_clear;
    logic [CW-1:0]      cycle_num;
    logic [RW-1:0]      out_row_sel;
    logic               sram_write_enable_a0;
    logic [WADDR_W-1:0] sram_waddr_a;
    logic               tpu_busy;
    logic               tpu_done;
    logic               err_cfg;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tpu_seq_ctrl #(
        .ARRAY_SIZE(ARRAY_SIZE), .ADDR_W(ADDR_W), .WADDR_W(WADDR_W),
        .MAX_K(MAX_K), .MAX_SETS(MAX_SETS)
    ) dut (
        .clk(clk), .srstn(srstn), .tpu_start(tpu_start), .abort(abort),
        .cfg_k(cfg_k), .cfg_sets(cfg_sets), .wr_ready(wr_ready),
        .sram_ren(sram_ren), .sram_raddr(sram_raddr), .alu_start(alu_start),
        .acc_clear(acc_clear), .cycle_num(cycle_num), .out_row_sel(out_row_sel),
        .sram_write_enable_a0(sram_write_enable_a0), .sram_waddr_a(sram_waddr_a),
        .tpu_busy(tpu_busy), .tpu_done(tpu_done), .err_cfg(err_cfg)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // After return the first FEED cycle is on the outputs.
    task automatic pulse_start(input int k, input int s);
        cfg_k     = KW'(k);
        cfg_sets  = SW'(s);
        tpu_start = 1'b1;
        step();
        tpu_start = 1'b0;
    endtask

    task automatic test_reset();
        srstn = 1'b0; tpu_start = 1'b0; abort = 1'b0;
        cfg_k = '0; cfg_sets = '0; wr_ready = 1'b0;
        repeat (2) step();
        n_checks++; if ({sram_ren, alu_start, acc_clear, sram_write_enable_a0, tpu_busy, tpu_done, err_cfg} !== 7'b0) begin n_errors++; $display("FAIL reset_strobes: got %b expected 0000000", {sram_ren, alu_start, acc_clear, sram_write_enable_a0, tpu_busy, tpu_done, err_cfg}); end
        n_checks++; if ({sram_raddr, sram_waddr_a, cycle_num, out_row_sel} !== '0) begin n_errors++; $display("FAIL reset_buses: raddr %0d waddr %0d cyc %0d row %0d expected all 0", sram_raddr, sram_waddr_a, cycle_num, out_row_sel); end
        srstn = 1'b1;
        step();
        n_checks++; if ({sram_ren, alu_start, tpu_busy, tpu_done, err_cfg} !== 5'b0) begin n_errors++; $display("FAIL idle_after_reset: got %b expected 00000", {sram_ren, alu_start, tpu_busy, tpu_done, err_cfg}); end
    endtask

    task automatic test_single();
        int wait_cnt;
        wr_ready = 1'b1;
        pulse_start(8, 1);
        for (int c = 0; c < 23; c++) begin
            if (c != 0) step();
            n_checks++; if (cycle_num !== CW'(c) || alu_start !== 1'b1 || tpu_busy !== 1'b1) begin n_errors++; $display("FAIL single_feed c=%0d: cyc %0d alu %b busy %b expected cyc %0d alu 1 busy 1", c, cycle_num, alu_start, tpu_busy, c); end
            n_checks++; if (sram_ren !== ((c < 8) ? 1'b1 : 1'b0) || sram_raddr !== ADDR_W'((c < 8) ? c : 7)) begin n_errors++; $display("FAIL single_raddr c=%0d: ren %b raddr %0d expected ren %b raddr %0d", c, sram_ren, sram_raddr, (c < 8), (c < 8) ? c : 7); end
            n_checks++; if (acc_clear !== ((c == 0) ? 1'b1 : 1'b0)) begin n_errors++; $display("FAIL single_acc c=%0d: got %b expected %b", c, acc_clear, (c == 0)); end
        end
        for (int r = 0; r < 8; r++) begin
            step();
            n_checks++; if (sram_write_enable_a0 !== 1'b1 || sram_waddr_a !== WADDR_W'(r) || out_row_sel !== RW'(r) || alu_start !== 1'b0 || sram_ren !== 1'b0) begin n_errors++; $display("FAIL single_write r=%0d: we %b waddr %0d row %0d alu %b ren %b expected we 1 waddr %0d row %0d alu 0 ren 0", r, sram_write_enable_a0, sram_waddr_a, out_row_sel, alu_start, sram_ren, r, r); end
        end
        step();
        n_checks++; if (tpu_done !== 1'b1 || tpu_busy !== 1'b1 || sram_write_enable_a0 !== 1'b0) begin n_errors++; $display("FAIL single_done: done %b busy %b we %b expected 1 1 0", tpu_done, tpu_busy, sram_write_enable_a0); end
        step();
        n_checks++; if (tpu_done !== 1'b0 || tpu_busy !== 1'b0) begin n_errors++; $display("FAIL single_done_pulse: done %b busy %b expected 0 0", tpu_done, tpu_busy); end
        wait_cnt = 0;
        repeat (5) begin step(); if (tpu_done === 1'b1) wait_cnt++; end
        n_checks++; if (wait_cnt != 0) begin n_errors++; $display("FAIL single_extra_done: got %0d pulses expected 0", wait_cnt); end
    endtask

    task automatic test_multi();
        int acc_cnt = 0;
        int we_cnt  = 0;
        int exp_a;
        wr_ready = 1'b1;
        pulse_start(16, 3);
        for (int s = 0; s < 3; s++) begin
            for (int c = 0; c < 31; c++) begin
                if (!(s == 0 && c == 0)) step();
                if (acc_clear === 1'b1) acc_cnt++;
                exp_a = s*16 + ((c < 16) ? c : 15);
                n_checks++; if (sram_ren !== ((c < 16) ? 1'b1 : 1'b0) || sram_raddr !== ADDR_W'(exp_a)) begin n_errors++; $display("FAIL multi_raddr s=%0d c=%0d: ren %b raddr %0d expected ren %b raddr %0d", s, c, sram_ren, sram_raddr, (c < 16), exp_a); end
            end
            for (int r = 0; r < 8; r++) begin
                step();
                if (acc_clear === 1'b1) acc_cnt++;
                if (sram_write_enable_a0 === 1'b1) we_cnt++;
                n_checks++; if (sram_write_enable_a0 !== 1'b1 || sram_waddr_a !== WADDR_W'(s*8 + r)) begin n_errors++; $display("FAIL multi_waddr s=%0d r=%0d: we %b waddr %0d expected we 1 waddr %0d", s, r, sram_write_enable_a0, sram_waddr_a, s*8 + r); end
            end
        end
        step();
        n_checks++; if (tpu_done !== 1'b1) begin n_errors++; $display("FAIL multi_done: got %b expected 1", tpu_done); end
        n_checks++; if (acc_cnt != 3) begin n_errors++; $display("FAIL multi_acc_count: got %0d expected 3", acc_cnt); end
        n_checks++; if (we_cnt != 24) begin n_errors++; $display("FAIL multi_write_count: got %0d expected 24", we_cnt); end
        step();
    endtask

    task automatic test_stall();
        logic [3:0] pat = 4'b1001;
        logic       rdy;
        int         exp_row, idx, act;
        wr_ready = 1'b0;
        pulse_start(8, 2);
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 23; c++) begin
                if (!(s == 0 && c == 0)) step();
                n_checks++; if (sram_raddr !== ADDR_W'(s*8 + ((c < 8) ? c : 7)) || acc_clear !== ((c == 0) ? 1'b1 : 1'b0)) begin n_errors++; $display("FAIL stall_feed s=%0d c=%0d: raddr %0d acc %b expected raddr %0d acc %b", s, c, sram_raddr, acc_clear, s*8 + ((c < 8) ? c : 7), (c == 0)); end
            end
            exp_row = 0; idx = 0; act = 0;
            while (exp_row < 8 && idx < 64) begin
                rdy = pat[idx % 4];
                wr_ready = rdy;
                step();
                if (sram_write_enable_a0 === 1'b1) act++;
                n_checks++; if (sram_write_enable_a0 !== rdy || sram_waddr_a !== WADDR_W'(s*8 + exp_row) || out_row_sel !== RW'(exp_row)) begin n_errors++; $display("FAIL stall_write s=%0d i=%0d: we %b waddr %0d row %0d expected we %b waddr %0d row %0d", s, idx, sram_write_enable_a0, sram_waddr_a, out_row_sel, rdy, s*8 + exp_row, exp_row); end
                if (rdy) exp_row++;
                idx++;
            end
            wr_ready = 1'b0;
            n_checks++; if (act != 8) begin n_errors++; $display("FAIL stall_strobe_count s=%0d: got %0d expected 8", s, act); end
        end
        step();
        n_checks++; if (tpu_done !== 1'b1) begin n_errors++; $display("FAIL stall_done: got %b expected 1", tpu_done); end
        step();
    endtask

    task automatic test_cfg_err();
        int ks [5] = '{0, 8, 65, 8, 64};
        int ss [5] = '{1, 17, 1, 0, 16};
        logic exp_err [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            cfg_k = KW'(ks[i]); cfg_sets = SW'(ss[i]); tpu_start = 1'b1;
            step();
            tpu_start = 1'b0;
            n_checks++; if (err_cfg !== exp_err[i] || tpu_busy !== ~exp_err[i]) begin n_errors++; $display("FAIL cfg_check k=%0d s=%0d: err %b busy %b expected err %b busy %b", ks[i], ss[i], err_cfg, tpu_busy, exp_err[i], ~exp_err[i]); end
            if (exp_err[i]) begin
                n_checks++; if (sram_ren !== 1'b0 || alu_start !== 1'b0 || tpu_done !== 1'b0) begin n_errors++; $display("FAIL cfg_quiet k=%0d s=%0d: ren %b alu %b done %b expected 0 0 0", ks[i], ss[i], sram_ren, alu_start, tpu_done); end
                step();
                n_checks++; if (err_cfg !== 1'b0 || tpu_busy !== 1'b0) begin n_errors++; $display("FAIL cfg_err_pulse k=%0d s=%0d: err %b busy %b expected 0 0", ks[i], ss[i], err_cfg, tpu_busy); end
            end else begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                n_checks++; if (tpu_busy !== 1'b0 || err_cfg !== 1'b0) begin n_errors++; $display("FAIL cfg_max_abort: busy %b err %b expected 0 0", tpu_busy, err_cfg); end
            end
        end
    endtask

    task automatic test_abort();
        int bad, cnt;
        wr_ready = 1'b1;
        pulse_start(8, 1);
        repeat (5) step();
        n_checks++; if (cycle_num !== CW'(5)) begin n_errors++; $display("FAIL abort_feed_pos: cyc %0d expected 5", cycle_num); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_checks++; if ({tpu_busy, alu_start, sram_ren, tpu_done, err_cfg} !== 5'b0 || cycle_num !== '0) begin n_errors++; $display("FAIL abort_feed: busy/alu/ren/done/err %b cyc %0d expected 00000 0", {tpu_busy, alu_start, sram_ren, tpu_done, err_cfg}, cycle_num); end
        bad = 0;
        repeat (40) begin step(); if (tpu_done === 1'b1 || tpu_busy === 1'b1) bad++; end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL abort_feed_quiet: got %0d active cycles expected 0", bad); end
        pulse_start(8, 1);
        repeat (26) step();
        n_checks++; if (out_row_sel !== RW'(3) || sram_write_enable_a0 !== 1'b1 || sram_waddr_a !== WADDR_W'(3)) begin n_errors++; $display("FAIL abort_write_pos: row %0d we %b waddr %0d expected 3 1 3", out_row_sel, sram_write_enable_a0, sram_waddr_a); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_checks++; if ({tpu_busy, sram_write_enable_a0, tpu_done} !== 3'b0 || out_row_sel !== '0) begin n_errors++; $display("FAIL abort_write: busy/we/done %b row %0d expected 000 0", {tpu_busy, sram_write_enable_a0, tpu_done}, out_row_sel); end
        bad = 0;
        repeat (10) begin step(); if (tpu_done === 1'b1 || sram_write_enable_a0 === 1'b1) bad++; end
        n_checks++; if (bad != 0) begin n_errors++; $display("FAIL abort_write_quiet: got %0d active cycles expected 0", bad); end
        cfg_k = KW'(8); cfg_sets = SW'(1); tpu_start = 1'b1; abort = 1'b1;
        step();
        tpu_start = 1'b0; abort = 1'b0;
        n_checks++; if (tpu_busy !== 1'b0 || sram_ren !== 1'b0 || err_cfg !== 1'b0) begin n_errors++; $display("FAIL abort_priority: busy %b ren %b err %b expected 0 0 0", tpu_busy, sram_ren, err_cfg); end
        pulse_start(8, 1);
        n_checks++; if (sram_ren !== 1'b1 || sram_raddr !== '0 || acc_clear !== 1'b1) begin n_errors++; $display("FAIL abort_restart_first: ren %b raddr %0d acc %b expected 1 0 1", sram_ren, sram_raddr, acc_clear); end
        step();
        n_checks++; if (sram_raddr !== ADDR_W'(1) || acc_clear !== 1'b0) begin n_errors++; $display("FAIL abort_restart_second: raddr %0d acc %b expected 1 0", sram_raddr, acc_clear); end
        cnt = 1;
        while (tpu_done !== 1'b1 && cnt < 100) begin step(); cnt++; end
        n_checks++; if (cnt != 31) begin n_errors++; $display("FAIL abort_restart_done: done after %0d cycles expected 31", cnt); end
        step();
    endtask

    task automatic test_reset_mid();
        int cnt;
        wr_ready = 1'b1;
        pulse_start(8, 2);
        repeat (3) step();
        cfg_k = KW'(16); cfg_sets = SW'(1); tpu_start = 1'b1;
        step();
        tpu_start = 1'b0;
        n_checks++; if (cycle_num !== CW'(4) || sram_raddr !== ADDR_W'(4) || err_cfg !== 1'b0) begin n_errors++; $display("FAIL busy_start_ignored: cyc %0d raddr %0d err %b expected 4 4 0", cycle_num, sram_raddr, err_cfg); end
        repeat (27) step();
        n_checks++; if (sram_raddr !== ADDR_W'(8) || acc_clear !== 1'b1 || tpu_done !== 1'b0) begin n_errors++; $display("FAIL busy_start_cfg_kept: raddr %0d acc %b done %b expected 8 1 0", sram_raddr, acc_clear, tpu_done); end
        repeat (25) step();
        n_checks++; if (sram_waddr_a !== WADDR_W'(10) || out_row_sel !== RW'(2)) begin n_errors++; $display("FAIL midreset_pos: waddr %0d row %0d expected 10 2", sram_waddr_a, out_row_sel); end
        srstn = 1'b0;
        #1;
        n_checks++; if ({sram_ren, alu_start, acc_clear, sram_write_enable_a0, tpu_busy, tpu_done, err_cfg} !== 7'b0 || {sram_raddr, sram_waddr_a, cycle_num, out_row_sel} !== '0) begin n_errors++; $display("FAIL midreset_async: strobes %b raddr %0d waddr %0d expected all 0", {sram_ren, alu_start, acc_clear, sram_write_enable_a0, tpu_busy, tpu_done, err_cfg}, sram_raddr, sram_waddr_a); end
        repeat (2) step();
        n_checks++; if ({tpu_busy, tpu_done, sram_write_enable_a0} !== 3'b0) begin n_errors++; $display("FAIL midreset_hold: busy/done/we %b expected 000", {tpu_busy, tpu_done, sram_write_enable_a0}); end
        srstn = 1'b1;
        step();
        pulse_start(8, 1);
        n_checks++; if (sram_ren !== 1'b1 || sram_raddr !== '0 || tpu_busy !== 1'b1) begin n_errors++; $display("FAIL midreset_restart: ren %b raddr %0d busy %b expected 1 0 1", sram_ren, sram_raddr, tpu_busy); end
        cnt = 0;
        while (tpu_done !== 1'b1 && cnt < 100) begin step(); cnt++; end
        n_checks++; if (cnt != 31) begin n_errors++; $display("FAIL midreset_done: done after %0d cycles expected 31", cnt); end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_stall();
        test_cfg_err();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
